// File: rtl/sat_acc_pkg.sv
// sat_acc_pkg: shared FSM state type and saturation limit helpers for sat_accumulator
package sat_acc_pkg;
    typedef enum logic {ST_ACC, ST_OUT} state_t;

    // Largest representable value of a w-bit number, signed or unsigned
    function automatic logic [63:0] max_val(input int w, input bit s);
        return s ? (64'd1 << (w - 1)) - 64'd1 : (64'd1 << w) - 64'd1;
    endfunction

    // Smallest representable value of a w-bit number, signed or unsigned
    function automatic logic [63:0] min_val(input int w, input bit s);
        return s ? ~64'd0 << (w - 1) : 64'd0;
    endfunction
endpackage

// File: rtl/sat_add.sv
// sat_add: combinational extend, add, overflow detect and clamp
//   acc_in  - current accumulator value (ACC_W)
//   data_in - new sample (IN_W)
//   sum_out - next accumulator value, clamped or wrapped (ACC_W)
//   ovf_out - the addition overflowed the accumulator range
module sat_add
    import sat_acc_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int ACC_W    = 16,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [IN_W-1:0]  data_in,
    output logic [ACC_W-1:0] sum_out,
    output logic             ovf_out
);
    localparam logic [ACC_W-1:0] MAXV = ACC_W'(max_val(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] MINV = ACC_W'(min_val(ACC_W, SIGNED != 0));

    logic             fill;
    logic [ACC_W:0]   ext;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] clamp;

    // One guard bit above ACC_W exposes the carry/sign-overflow of the add
    assign fill    = (SIGNED != 0) ? data_in[IN_W-1] : 1'b0;
    assign ext     = {{(ACC_W + 1 - IN_W){fill}}, data_in};
    assign sum     = {(SIGNED != 0) ? acc_in[ACC_W-1] : 1'b0, acc_in} + ext;
    assign ovf_out = (SIGNED != 0) ? sum[ACC_W] ^ sum[ACC_W-1] : sum[ACC_W];
    // A signed overflow always goes in the direction of the sample's sign
    assign clamp   = (SIGNED != 0 && ext[ACC_W]) ? MINV : MAXV;
    assign sum_out = (ovf_out && SATURATE != 0) ? clamp : sum[ACC_W-1:0];
endmodule

// File: rtl/sat_accumulator.sv
// sat_accumulator: frame accumulator with saturate/wrap and valid/ready result output
//   clk, rst_n          - clock, synchronous active-low reset
//   clear               - synchronous frame flush, beats both handshakes
//   cfg_len             - samples per frame (0 means 1), latched on first sample
//   s_valid/s_ready/s_data         - sample input stream
//   m_valid/m_ready/m_data/m_count/m_ovf - per-frame result stream
module sat_accumulator
    import sat_acc_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int ACC_W    = 16,
    parameter int CNT_W    = 8,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_data,
    output logic [CNT_W-1:0] m_count,
    output logic             m_ovf
);
    state_t           state, state_d;
    logic [ACC_W-1:0] acc, acc_sum;
    logic [CNT_W-1:0] count, count_inc, len_q, len_src, len_eff;
    logic             ovf, add_ovf, s_hs, m_hs, last;

    sat_add #(
        .IN_W    (IN_W),
        .ACC_W   (ACC_W),
        .SIGNED  (SIGNED),
        .SATURATE(SATURATE)
    ) u_add (
        .acc_in (acc),
        .data_in(s_data),
        .sum_out(acc_sum),
        .ovf_out(add_ovf)
    );

    assign s_ready   = (state == ST_ACC);
    assign m_valid   = (state == ST_OUT);
    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid && m_ready;
    assign m_data    = acc;
    assign m_count   = count;
    assign m_ovf     = ovf;
    // On the first sample len_q is not yet loaded, so use cfg_len directly
    assign len_src   = (count == '0) ? cfg_len : len_q;
    assign len_eff   = (len_src == '0) ? CNT_W'(1) : len_src;
    assign count_inc = count + CNT_W'(1);
    assign last      = (count_inc == len_eff);

    always_comb begin
        state_d = state;
        if (clear)
            state_d = ST_ACC;
        else if (s_hs && last)
            state_d = ST_OUT;
        else if (m_hs)
            state_d = ST_ACC;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_ACC;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            len_q <= '0;
        end else if (clear || m_hs) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (s_hs) begin
            acc   <= acc_sum;
            count <= count_inc;
            ovf   <= ovf | add_ovf;
            if (count == '0)
                len_q <= cfg_len;
        end
    end
endmodule

// File: tb/tb_sat_accumulator.sv
// tb_sat_accumulator: directed scoreboard bench for signed-saturate and unsigned-wrap builds
module tb_sat_accumulator;
    typedef struct {
        logic [9:0] sd;
        logic       so;
        logic [9:0] ud;
        logic       uo;
        logic [7:0] c;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n, clear, s_valid, m_ready;
    logic [7:0] cfg_len, s_data;
    logic       s_ready_s, m_valid_s, m_ovf_s, s_ready_u, m_valid_u, m_ovf_u;
    logic [9:0] m_data_s, m_data_u;
    logic [7:0] m_count_s, m_count_u;

    res_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   acc_s = 0, acc_u = 0, cnt = 0, len = 0;
    bit   ovs = 0, ovu = 0, busy = 0;

    always #5 clk = ~clk;

    sat_accumulator #(.IN_W(8), .ACC_W(10), .CNT_W(8), .SIGNED(1), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data),
        .m_valid(m_valid_s), .m_ready(m_ready), .m_data(m_data_s),
        .m_count(m_count_s), .m_ovf(m_ovf_s)
    );

    sat_accumulator #(.IN_W(8), .ACC_W(10), .CNT_W(8), .SIGNED(0), .SATURATE(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_ready(s_ready_u), .s_data(s_data),
        .m_valid(m_valid_u), .m_ready(m_ready), .m_data(m_data_u),
        .m_count(m_count_u), .m_ovf(m_ovf_u)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        acc_s = 0;
        acc_u = 0;
        cnt   = 0;
        ovs   = 0;
        ovu   = 0;
    endtask

    task automatic check_zero();
        check("rst_m_valid_s", 32'(m_valid_s), 0);
        check("rst_m_data_s",  32'(m_data_s),  0);
        check("rst_m_count_s", 32'(m_count_s), 0);
        check("rst_m_ovf_s",   32'(m_ovf_s),   0);
        check("rst_m_valid_u", 32'(m_valid_u), 0);
        check("rst_m_data_u",  32'(m_data_u),  0);
        check("rst_m_count_u", 32'(m_count_u), 0);
        check("rst_m_ovf_u",   32'(m_ovf_u),   0);
    endtask

    // Checks the present outputs against the model, drives one cycle of
    // inputs, advances the model by what that edge should do, then clocks.
    task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        check("s_ready_s", 32'(s_ready_s), 32'(!busy));
        check("s_ready_u", 32'(s_ready_u), 32'(!busy));
        check("m_valid_s", 32'(m_valid_s), 32'(busy));
        check("m_valid_u", 32'(m_valid_u), 32'(busy));
        if (busy) begin
            check("m_data_s",  32'(m_data_s),  32'(q[0].sd));
            check("m_ovf_s",   32'(m_ovf_s),   32'(q[0].so));
            check("m_count_s", 32'(m_count_s), 32'(q[0].c));
            check("m_data_u",  32'(m_data_u),  32'(q[0].ud));
            check("m_ovf_u",   32'(m_ovf_u),   32'(q[0].uo));
            check("m_count_u", 32'(m_count_u), 32'(q[0].c));
        end
        s_valid = v;
        s_data  = d;
        m_ready = rdy;
        clear   = clr;
        if (!rst_n) begin
            model_reset();
            q.delete();
            busy = 0;
        end else if (clr) begin
            if (busy) void'(q.pop_front());
            busy = 0;
            model_reset();
        end else if (busy) begin
            if (rdy) begin
                void'(q.pop_front());
                busy = 0;
            end
        end else if (v) begin
            if (cnt == 0) len = (cfg_len == 0) ? 1 : int'(cfg_len);
            acc_s = acc_s + int'($signed(d));
            if (acc_s > 511) begin acc_s = 511; ovs = 1; end
            else if (acc_s < -512) begin acc_s = -512; ovs = 1; end
            acc_u = acc_u + int'(d);
            if (acc_u > 1023) begin acc_u = acc_u - 1024; ovu = 1; end
            cnt++;
            if (cnt == len) begin
                q.push_back('{10'(acc_s), ovs, 10'(acc_u), ovu, 8'(cnt)});
                model_reset();
                busy = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] mix [5];
        mix = '{8'd10, 8'hFD, 8'd7, 8'hEC, 8'd6};
        rst_n = 0; clear = 0; s_valid = 0; s_data = 0; m_ready = 0; cfg_len = 0;
        @(posedge clk);
        #1;
        check_zero();
        step(1, 8'd33, 1, 0);
        check_zero();
        rst_n = 1;
        cfg_len = 5;
        repeat (5) step(1, 8'd127, 1, 0);
        step(0, 0, 1, 0);
        repeat (5) step(1, 8'h80, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, mix[i], 1, 0);
        step(0, 0, 1, 0);
        cfg_len = 0;
        step(1, 8'd9, 1, 0);
        step(0, 0, 1, 0);
        cfg_len = 3;
        step(1, 8'd1, 0, 0);
        cfg_len = 7;
        step(1, 8'd2, 0, 0);
        step(1, 8'd3, 0, 0);
        repeat (3) step(1, 8'd50, 0, 0);
        step(1, 8'd60, 1, 0);
        cfg_len = 2;
        step(1, 8'd4, 1, 0);
        step(1, 8'd5, 1, 0);
        step(0, 0, 1, 0);
        cfg_len = 4;
        step(1, 8'd5, 1, 0);
        step(1, 8'd6, 1, 0);
        step(1, 8'd100, 1, 1);
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 1, 0);
        step(0, 0, 1, 0);
        step(1, 8'd7, 1, 0);
        step(1, 8'd8, 1, 0);
        rst_n = 0;
        step(1, 8'd9, 1, 0);
        rst_n = 1;
        check_zero();
        step(0, 0, 1, 0);
        repeat (4) step(1, 8'd20, 0, 0);
        step(0, 0, 0, 0);
        rst_n = 0;
        step(0, 0, 1, 0);
        rst_n = 1;
        check_zero();
        step(0, 0, 1, 0);
        cfg_len = 255;
        repeat (255) step(1, 8'd1, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("queue_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
